// File: rtl/fifo_drain_serializer.sv
// rtl/fifo_drain_serializer.sv - pops words from an 8-bit FIFO and sends each as a start/data/parity/stop serial frame
module fifo_drain_serializer #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tx_enable,
    input  logic         fifo_empty,
    input  logic [N-1:0] fifo_data,
    output logic         fifo_rd_en,
    output logic         tx_serial,
    output logic         busy,
    output logic         byte_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(N + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(N - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t              state;
    logic [N-1:0]        shreg;
    logic                parity_bit;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            parity_bit <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            fifo_rd_en <= 1'b0;
            tx_serial  <= 1'b1;
            busy       <= 1'b0;
            byte_done  <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            byte_done  <= 1'b0;
            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    baud_cnt  <= '0;
                    if (tx_enable && !fifo_empty) begin
                        state      <= POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                POP: begin
                    tx_serial <= 1'b1;
                    state     <= LOAD;
                end
                // The popped word is valid on fifo_data one edge after rd_en was sampled.
                LOAD: begin
                    shreg      <= fifo_data;
                    parity_bit <= ^fifo_data;
                    baud_cnt   <= '0;
                    bit_cnt    <= '0;
                    tx_serial  <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        tx_serial <= shreg[0];
                        state     <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                tx_serial <= parity_bit;
                                state     <= PARITY;
                            end else begin
                                tx_serial <= 1'b1;
                                state     <= STOP;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shreg     <= {1'b0, shreg[N-1:1]};
                            tx_serial <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        tx_serial <= 1'b1;
                        state     <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    tx_serial <= 1'b1;
                    // Registered pulse, so it is raised one cycle ahead to land on the final stop cycle.
                    if (baud_cnt == BAUD_PRE) begin
                        byte_done <= 1'b1;
                    end
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (tx_enable && !fifo_empty) begin
                            state      <= POP;
                            fifo_rd_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    tx_serial <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
